axis_insert_header_multi: RTL and testbench
===========================================

Name: axis_insert_header_multi

Overview:
- Prepends a variable-length header of 0..MAX_HDR_BEATS*DATA_BYTE_WD bytes to each AXI-Stream packet.
- The header may span several beats. Header and payload bytes are packed with no null bytes; only the final output beat is partial.
- Sits between the packet source and the egress register slice. It is the multi-beat, byte-exact successor of the single-beat header inserter.
- Throughput is 1 beat/clk within a packet. Registered output.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (NB).
- MAX_HDR_BEATS, 4, maximum header length in beats.
- HDR_WD, DATA_WD*MAX_HDR_BEATS, header bus width.
- HDR_CNT_WD, $clog2(DATA_BYTE_WD*MAX_HDR_BEATS+1), header byte-count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  payload valid
- data_in  in  DATA_WD  payload data; byte i = data_in[8i+7:8i], byte 0 first on the wire
- keep_in  in  DATA_BYTE_WD  contiguous from bit 0; all-ones except on the last beat
- last_in  in  1  payload last beat
- ready_in  out  1  payload ready
- valid_insert  in  1  header valid (one header per packet)
- data_insert  in  HDR_WD  header bytes, byte 0 = data_insert[7:0]
- hdr_len  in  HDR_CNT_WD  header byte count; 0 = passthrough
- ready_insert  out  1  header ready
- valid_out  out  1  output valid
- data_out  out  DATA_WD  output data
- keep_out  out  DATA_BYTE_WD  output keep, contiguous from bit 0
- last_out  out  1  output last
- ready_out  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release):
  - valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=0.
  - State=IDLE. Residual and header registers cleared.
  - ready_insert goes to 1 the first cycle after release.
- Reset mid-packet drops all buffered bytes. No partial packet is emitted afterwards.
- adv = !valid_out || ready_out. The output register loads only when adv=1 and holds stable while valid_out && !ready_out.
- Length clamping: hdr_len > NB*MAX_HDR_BEATS is clamped to NB*MAX_HDR_BEATS.
- Header latch: on the header handshake, latch data_insert into hdr_reg, and set FB = len/NB (full header beats) and R = len%NB (residual byte count, held for the packet).
- IDLE:
  - ready_insert=1, ready_in=0.
  - On valid_insert: latch as above.
  - If FB>0, go to HDR with beat index k=0.
  - Otherwise load residual = hdr bytes [R-1:0] and go to PAY.
- HDR:
  - ready_insert=0, ready_in=0.
  - When adv: output hdr beat k with keep all-ones and last=0; k++.
  - After beat FB-1: residual = hdr bytes [FB*NB+R-1 : FB*NB], go to PAY.
- PAY:
  - ready_in = adv. Let n = popcount(keep_in).
  - Merged word = residual (R low bytes) | (data_in << 8R).
  - Non-last beat: output merged low NB bytes, keep all-ones. New residual = data_in bytes [NB-1 : NB-R].
  - Last beat with R+n <= NB: output merged with keep = R+n low bits and last=1; go to IDLE.
  - Last beat with R+n > NB: output NB bytes with last=0; residual = upper R+n-NB bytes; go to TAIL.
  - R=0 is pure passthrough with 0 added latency beyond the output register.
- TAIL:
  - ready_in=0, ready_insert=0.
  - When adv: output residual with keep = (R+n-NB) low bits and last=1; go to IDLE.
- Latency: valid_in/header handshake to valid_out is 1 clk.
- Inter-packet gap is at least 1 clk (IDLE header accept). This gap is acceptable.
- valid_insert while not in IDLE is ignored (ready_insert=0). valid_in in IDLE/HDR/TAIL is stalled.
- A zero-byte payload is illegal: the last beat requires keep_in[0]=1. Non-contiguous keep_in gives undefined output.
- Output keep_out is never 0 when valid_out=1.

Decomposition:
- Package axis_hdr_pkg:
  - state enum {IDLE, HDR, PAY, TAIL};
  - function keep_from_cnt(cnt) (thermometer mask);
  - function byte_cnt(keep) (popcount).
- Sub-module axis_out_slice: a one-deep output register (valid/data/keep/last, load on adv), async active-low reset. The FSM and merge datapath stay in the top module.

Test Plan:
- NB=4, hdr_len=6 (bytes 01..06), payload 0x14131211, 0x18171615 keep F last -> out 0x04030201 F, 0x12110605 F, 0x16151413 F, 0x00001817 keep 0011 last; ready_in deasserted exactly 1 clk (TAIL).
- hdr_len=3 (01..03), payload 0x14131211 F, 0x00000015 keep 0001 last -> out 0x11030201 F, 0x15141312 F last; no TAIL cycle, ready_in never drops mid-packet.
- hdr_len=0, payload 3 beats, last keep 0011 -> output identical to input, 1-clk latency, 1 beat/clk.
- hdr_len=16 (max) and hdr_len=20 (clamped) with 1-byte payload 0xAA -> 4 full header beats then 0x000000AA keep 0001 last.
- Random ready_out (50%) and valid_in gaps over 1000 packets with random hdr_len 0..16 and payload 1..64 bytes -> scoreboard byte-exact. valid_out, data_out, keep_out and last_out stay stable while stalled.
- rst_n low for 1 clk during PAY -> valid_out=0 asynchronously; ready_insert=1 the cycle after release; next packet (hdr_len=5) output correct with no stale bytes.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-lane helpers for the multi-beat AXI-Stream header inserter.
// Helpers work on a fixed wide mask; callers size-cast the result to their lane count.
package axis_hdr_pkg;

  typedef enum logic [1:0] {IDLE, HDR, PAY, TAIL} state_t;

  localparam int MAX_NB = 64;

  // Thermometer mask with the low cnt bits set.
  function automatic logic [MAX_NB-1:0] keep_from_cnt(input int unsigned cnt);
    logic [MAX_NB-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_NB; i++) begin
      if (i < cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Number of set bits in a keep mask.
  function automatic int unsigned byte_cnt(input logic [MAX_NB-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_NB; i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_out_slice.sv
// One-deep output register: captures a beat whenever the downstream can advance,
// otherwise holds the presented beat stable.
module axis_out_slice #(
  parameter int DATA_WD = 32,
  parameter int BYTE_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               beat_valid,
  input  logic [DATA_WD-1:0] beat_data,
  input  logic [BYTE_WD-1:0] beat_keep,
  input  logic               beat_last,
  output logic               valid,
  output logic [DATA_WD-1:0] data,
  output logic [BYTE_WD-1:0] keep,
  output logic               last
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= beat_valid;
      data  <= beat_data;
      keep  <= beat_keep;
      last  <= beat_last;
    end
  end

endmodule

// File: rtl/axis_insert_header_multi.sv
// Prepends a 0..MAX_HDR_BEATS*NB byte header to each AXI-Stream packet, packing
// header and payload bytes densely so only the final output beat is partial.
module axis_insert_header_multi
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD       = 32,
  parameter int DATA_BYTE_WD  = DATA_WD / 8,
  parameter int MAX_HDR_BEATS = 4,
  parameter int HDR_WD        = DATA_WD * MAX_HDR_BEATS,
  parameter int HDR_CNT_WD    = $clog2(DATA_BYTE_WD * MAX_HDR_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [HDR_WD-1:0]       data_insert,
  input  logic [HDR_CNT_WD-1:0]   hdr_len,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int NB = DATA_BYTE_WD;
  localparam logic [HDR_CNT_WD-1:0] NB_C      = HDR_CNT_WD'(NB);
  localparam logic [HDR_CNT_WD-1:0] MAX_BYTES = HDR_CNT_WD'(NB * MAX_HDR_BEATS);
  localparam logic [HDR_CNT_WD-1:0] ONE       = HDR_CNT_WD'(1);

  state_t                  state;
  logic                    init_done;
  logic [HDR_WD-1:0]       hdr_reg;
  logic [HDR_CNT_WD-1:0]   fb;
  logic [HDR_CNT_WD-1:0]   k;
  logic [HDR_CNT_WD-1:0]   r;
  logic [HDR_CNT_WD-1:0]   tail_cnt;
  logic [DATA_WD-1:0]      resid;

  logic                    adv;
  logic [HDR_CNT_WD-1:0]   len_c;
  logic [HDR_CNT_WD-1:0]   len_fb;
  logic [HDR_CNT_WD-1:0]   len_r;
  logic [HDR_WD+DATA_WD-1:0] hdr_ext;
  logic [DATA_WD-1:0]      hdr_k_word;
  logic [DATA_WD-1:0]      hdr_fb_word;
  logic [DATA_WD-1:0]      data_m;
  logic [DATA_WD-1:0]      resid_m;
  logic [2*DATA_WD-1:0]    merged;
  logic [HDR_CNT_WD-1:0]   pay_n;
  logic [HDR_CNT_WD-1:0]   tot;
  logic                    fits;

  logic                    beat_valid;
  logic [DATA_WD-1:0]      beat_data;
  logic [NB-1:0]           beat_keep;
  logic                    beat_last;

  assign adv          = !valid_out || ready_out;
  assign ready_in     = (state == PAY) && adv;
  assign ready_insert = (state == IDLE) && init_done;

  assign len_c  = (hdr_len > MAX_BYTES) ? MAX_BYTES : hdr_len;
  assign len_fb = len_c / NB_C;
  assign len_r  = len_c % NB_C;

  // A zero word above the header lets a full-length header select an all-zero residual.
  assign hdr_ext     = {{DATA_WD{1'b0}}, hdr_reg};
  assign hdr_k_word  = hdr_ext[int'(k) * DATA_WD +: DATA_WD];
  assign hdr_fb_word = hdr_ext[int'(fb) * DATA_WD +: DATA_WD];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    data_m  = '0;
    resid_m = '0;
    for (int i = 0; i < NB; i++) begin
      if (keep_in[i])              data_m[8*i +: 8]  = data_in[8*i +: 8];
      if (HDR_CNT_WD'(i) < r)      resid_m[8*i +: 8] = resid[8*i +: 8];
    end
  end

  assign pay_n  = HDR_CNT_WD'(byte_cnt(MAX_NB'(keep_in)));
  assign tot    = r + pay_n;
  assign fits   = (tot <= NB_C);
  // Residual bytes sit in the low R lanes; payload is shifted up behind them.
  assign merged = {{DATA_WD{1'b0}}, resid_m} | ({{DATA_WD{1'b0}}, data_m} << {r, 3'b000});

  always_comb begin
    beat_valid = 1'b0;
    beat_data  = merged[DATA_WD-1:0];
    beat_keep  = '1;
    beat_last  = 1'b0;
    case (state)
      HDR: begin
        beat_valid = 1'b1;
        beat_data  = hdr_k_word;
      end
      PAY: begin
        beat_valid = valid_in;
        if (last_in && fits) begin
          beat_keep = NB'(keep_from_cnt(int'(tot)));
          beat_last = 1'b1;
        end
      end
      TAIL: begin
        beat_valid = 1'b1;
        beat_data  = resid;
        beat_keep  = NB'(keep_from_cnt(int'(tail_cnt)));
        beat_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      init_done <= 1'b0;
      hdr_reg   <= '0;
      fb        <= '0;
      k         <= '0;
      r         <= '0;
      tail_cnt  <= '0;
      resid     <= '0;
    end else begin
      init_done <= 1'b1;
      case (state)
        IDLE: begin
          if (ready_insert && valid_insert) begin
            hdr_reg <= data_insert;
            fb      <= len_fb;
            r       <= len_r;
            k       <= '0;
            if (len_fb != '0) begin
              state <= HDR;
            end else begin
              resid <= data_insert[DATA_WD-1:0];
              state <= PAY;
            end
          end
        end
        HDR: begin
          if (adv) begin
            k <= k + ONE;
            if (k == fb - ONE) begin
              resid <= hdr_fb_word;
              state <= PAY;
            end
          end
        end
        PAY: begin
          if (ready_in && valid_in) begin
            if (!last_in) begin
              resid <= merged[2*DATA_WD-1:DATA_WD];
            end else if (fits) begin
              state <= IDLE;
            end else begin
              resid    <= merged[2*DATA_WD-1:DATA_WD];
              tail_cnt <= tot - NB_C;
              state    <= TAIL;
            end
          end
        end
        TAIL: begin
          if (adv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_out_slice #(
    .DATA_WD (DATA_WD),
    .BYTE_WD (NB)
  ) u_out_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (adv),
    .beat_valid (beat_valid),
    .beat_data  (beat_data),
    .beat_keep  (beat_keep),
    .beat_last  (beat_last),
    .valid      (valid_out),
    .data       (data_out),
    .keep       (keep_out),
    .last       (last_out)
  );

endmodule

// File: tb/tb_axis_insert_header_multi.sv
// Self-checking bench: directed vector table, mid-packet reset sequence, and
// randomized traffic scored against a byte-stream reference model.
module tb_axis_insert_header_multi;

  localparam int DATA_WD       = 32;
  localparam int NB            = 4;
  localparam int MAX_HDR_BEATS = 4;
  localparam int HDR_WD        = DATA_WD * MAX_HDR_BEATS;
  localparam int HDR_CNT_WD    = 5;
  localparam int MAXB          = NB * MAX_HDR_BEATS;

  logic                  clk;
  logic                  rst_n;
  logic                  valid_in;
  logic [DATA_WD-1:0]    data_in;
  logic [NB-1:0]         keep_in;
  logic                  last_in;
  logic                  ready_in;
  logic                  valid_insert;
  logic [HDR_WD-1:0]     data_insert;
  logic [HDR_CNT_WD-1:0] hdr_len;
  logic                  ready_insert;
  logic                  valid_out;
  logic [DATA_WD-1:0]    data_out;
  logic [NB-1:0]         keep_out;
  logic                  last_out;
  logic                  ready_out;

  axis_insert_header_multi #(
    .DATA_WD       (DATA_WD),
    .DATA_BYTE_WD  (NB),
    .MAX_HDR_BEATS (MAX_HDR_BEATS),
    .HDR_WD        (HDR_WD),
    .HDR_CNT_WD    (HDR_CNT_WD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .ready_in     (ready_in),
    .valid_insert (valid_insert),
    .data_insert  (data_insert),
    .hdr_len      (hdr_len),
    .ready_insert (ready_insert),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out),
    .ready_out    (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic [NB-1:0]      keep;
    logic               last;
  } beat_t;

  typedef struct {
    logic [HDR_CNT_WD-1:0]     len;
    logic [HDR_WD-1:0]         hdr;
    int                        pay_n;
    logic [127:0]              pay;
    int                        n_exp;
    logic [4:0][DATA_WD-1:0]   ed;
    logic [4:0][NB-1:0]        ek;
    logic [4:0]                el;
    bit                        tail;
    bit                        chk_lat;
  } vec_t;

  vec_t        vecs[5];
  beat_t       exp_q[$];
  logic [7:0]  pay_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gap_pct = 0;
  bit ready_rand = 1'b0;
  bit mon_en = 1'b0;
  bit mon_first = 1'b0;
  int first_in_cyc, first_out_cyc, last_out_cyc, stalls;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1 ready_out = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on handshake, hold check while stalled.
  beat_t              mon_e;
  logic [DATA_WD-1:0] mon_mask;
  bit                 stall_pend = 1'b0;
  beat_t              stall_b;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 64'(valid_out), 64'(1));
        check("stall_data",  64'(data_out),  64'(stall_b.data));
        check("stall_keep",  64'(keep_out),  64'(stall_b.keep));
        check("stall_last",  64'(last_out),  64'(stall_b.last));
      end
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(data_out), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          mon_mask = '0;
          for (int b = 0; b < NB; b++) if (mon_e.keep[b]) mon_mask[8*b +: 8] = 8'hFF;
          check("out_data", 64'(data_out & mon_mask), 64'(mon_e.data & mon_mask));
          check("out_keep", 64'(keep_out), 64'(mon_e.keep));
          check("out_last", 64'(last_out), 64'(mon_e.last));
          if (mon_first) begin
            first_out_cyc = cyc;
            mon_first = 1'b0;
          end
          last_out_cyc = cyc;
        end
      end
      stall_pend = valid_out && !ready_out;
      stall_b    = '{data: data_out, keep: keep_out, last: last_out};
    end
  end

  // Reference model: header bytes then payload bytes as one stream, cut into NB-byte beats.
  task automatic model_push(input int len, input logic [HDR_WD-1:0] hdr);
    logic [7:0] s[$];
    beat_t      b;
    int         lc;
    lc = (len > MAXB) ? MAXB : len;
    for (int i = 0; i < lc; i++) s.push_back(hdr[8*i +: 8]);
    foreach (pay_q[i]) s.push_back(pay_q[i]);
    while (s.size() > 0) begin
      b = '0;
      for (int j = 0; j < NB && s.size() > 0; j++) begin
        b.data[8*j +: 8] = s.pop_front();
        b.keep[j] = 1'b1;
      end
      b.last = (s.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_pkt(input logic [HDR_CNT_WD-1:0] len, input logic [HDR_WD-1:0] hdr);
    int n, idx, t;
    n = pay_q.size();
    idx = 0;
    stalls = 0;
    @(posedge clk); #1;
    valid_insert = 1'b1;
    hdr_len      = len;
    data_insert  = hdr;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_insert && t < 2000);
    if (!ready_insert) begin
      check("hdr_accept_timeout", 64'(t), 64'(0));
      valid_insert = 1'b0;
      pay_q.delete();
      return;
    end
    @(posedge clk); #1;
    valid_insert = 1'b0;
    while (idx < n) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      data_in = '0;
      keep_in = '0;
      for (int b = 0; b < NB; b++) begin
        if (idx + b < n) begin
          data_in[8*b +: 8] = pay_q[idx + b];
          keep_in[b] = 1'b1;
        end
      end
      last_in  = (idx + NB >= n);
      valid_in = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (ready_in) break;
        if (idx > 0) stalls++;
        t++;
        if (t >= 2000) break;
      end
      if (!ready_in) begin
        check("pay_accept_timeout", 64'(t), 64'(0));
        valid_in = 1'b0;
        pay_q.delete();
        return;
      end
      if (idx == 0) first_in_cyc = cyc;
      @(posedge clk); #1;
      idx += NB;
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
    pay_q.delete();
  endtask

  task automatic drain(input int max_cyc);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  endtask

  task automatic set_exp(input int v, input int i, input logic [DATA_WD-1:0] d,
                         input logic [NB-1:0] kp, input logic l);
    vecs[v].ed[i] = d;
    vecs[v].ek[i] = kp;
    vecs[v].el[i] = l;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0]          pw;
    logic [HDR_WD-1:0]     rh;
    logic [HDR_CNT_WD-1:0] rl;
    beat_t                 b;
    int                    pn;

    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; hdr_len = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Vector table.
    vecs[0] = '{len: 5'd6, hdr: 128'h060504030201, pay_n: 8, pay: 128'h1817161514131211,
                n_exp: 4, ed: '0, ek: '0, el: '0, tail: 1'b1, chk_lat: 1'b0};
    set_exp(0, 0, 32'h04030201, 4'hF, 1'b0);
    set_exp(0, 1, 32'h12110605, 4'hF, 1'b0);
    set_exp(0, 2, 32'h16151413, 4'hF, 1'b0);
    set_exp(0, 3, 32'h00001817, 4'h3, 1'b1);
    vecs[1] = '{len: 5'd3, hdr: 128'h030201, pay_n: 5, pay: 128'h1514131211,
                n_exp: 2, ed: '0, ek: '0, el: '0, tail: 1'b0, chk_lat: 1'b0};
    set_exp(1, 0, 32'h11030201, 4'hF, 1'b0);
    set_exp(1, 1, 32'h15141312, 4'hF, 1'b1);
    vecs[2] = '{len: 5'd0, hdr: 128'hDEADBEEF_CAFEF00D, pay_n: 10, pay: 128'h2A292827262524232221,
                n_exp: 3, ed: '0, ek: '0, el: '0, tail: 1'b0, chk_lat: 1'b1};
    set_exp(2, 0, 32'h24232221, 4'hF, 1'b0);
    set_exp(2, 1, 32'h28272625, 4'hF, 1'b0);
    set_exp(2, 2, 32'h00002A29, 4'h3, 1'b1);
    for (int v = 3; v < 5; v++) begin
      vecs[v] = '{len: (v == 3) ? 5'd16 : 5'd20, hdr: 128'h100F0E0D0C0B0A090807060504030201,
                  pay_n: 1, pay: 128'hAA, n_exp: 5, ed: '0, ek: '0, el: '0,
                  tail: 1'b0, chk_lat: 1'b0};
      set_exp(v, 0, 32'h04030201, 4'hF, 1'b0);
      set_exp(v, 1, 32'h08070605, 4'hF, 1'b0);
      set_exp(v, 2, 32'h0C0B0A09, 4'hF, 1'b0);
      set_exp(v, 3, 32'h100F0E0D, 4'hF, 1'b0);
      set_exp(v, 4, 32'h000000AA, 4'h1, 1'b1);
    end

    // Reset state.
    @(negedge clk);
    check("rst_valid_out",    64'(valid_out),    64'(0));
    check("rst_data_out",     64'(data_out),     64'(0));
    check("rst_keep_out",     64'(keep_out),     64'(0));
    check("rst_last_out",     64'(last_out),     64'(0));
    check("rst_ready_in",     64'(ready_in),     64'(0));
    check("rst_ready_insert", 64'(ready_insert), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_ready_insert_0", 64'(ready_insert), 64'(0));
    @(posedge clk); @(negedge clk);
    check("release_ready_insert_1", 64'(ready_insert), 64'(1));
    mon_en = 1'b1;

    // Directed vectors, downstream always ready, no input gaps.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n_exp; i++)
        exp_q.push_back('{data: vecs[v].ed[i], keep: vecs[v].ek[i], last: vecs[v].el[i]});
      pw = vecs[v].pay;
      for (int i = 0; i < vecs[v].pay_n; i++) pay_q.push_back(pw[8*i +: 8]);
      mon_first = 1'b1;
      send_pkt(vecs[v].len, vecs[v].hdr);
      check($sformatf("v%0d_pay_stalls", v), 64'(stalls), 64'(0));
      @(negedge clk);
      check($sformatf("v%0d_after_last_ready_insert", v), 64'(ready_insert), 64'(!vecs[v].tail));
      if (vecs[v].tail) begin
        @(negedge clk);
        check($sformatf("v%0d_after_tail_ready_insert", v), 64'(ready_insert), 64'(1));
      end
      drain(200);
      if (vecs[v].chk_lat) begin
        check("pass_latency", 64'(first_out_cyc - first_in_cyc), 64'(1));
        check("pass_rate",    64'(last_out_cyc - first_out_cyc), 64'(vecs[v].n_exp - 1));
      end
    end

    // Reset mid-packet, then a clean packet with no stale bytes.
    mon_en = 1'b0;
    @(posedge clk); #1;
    valid_insert = 1'b1; hdr_len = 5'd5; data_insert = 128'hE5E4E3E2E1;
    pn = 0;
    do begin @(negedge clk); pn++; end while (!ready_insert && pn < 100);
    @(posedge clk); #1;
    valid_insert = 1'b0;
    valid_in = 1'b1; data_in = 32'hB4B3B2B1; keep_in = 4'hF; last_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_pkt_valid_out", 64'(valid_out), 64'(1));
    #2 rst_n = 1'b0;
    valid_in = 1'b0;
    #1 check("async_rst_valid_out", 64'(valid_out), 64'(0));
    check("async_rst_ready_in", 64'(ready_in), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_ready_insert", 64'(ready_insert), 64'(1));
    mon_en = 1'b1;
    exp_q.push_back('{data: 32'h34333231, keep: 4'hF, last: 1'b0});
    exp_q.push_back('{data: 32'h43424135, keep: 4'hF, last: 1'b0});
    exp_q.push_back('{data: 32'h00464544, keep: 4'h7, last: 1'b1});
    for (int i = 0; i < 6; i++) pay_q.push_back(8'(8'h41 + i));
    send_pkt(5'd5, 128'h3534333231);
    drain(200);

    // Randomized traffic with back-pressure and input gaps.
    ready_rand = 1'b1;
    gap_pct = 25;
    for (int p = 0; p < 1000; p++) begin
      rl = HDR_CNT_WD'($urandom_range(0, MAXB));
      rh = {$urandom(), $urandom(), $urandom(), $urandom()};
      pn = $urandom_range(1, 64);
      for (int i = 0; i < pn; i++) pay_q.push_back(8'($urandom()));
      model_push(int'(rl), rh);
      send_pkt(rl, rh);
    end
    drain(5000);
    ready_rand = 1'b0;
    repeat (4) @(negedge clk);
    b = '0;
    check("final_queue_empty", 64'(exp_q.size()), 64'(b.last));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
